// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: runs the data-memory request/ready handshake,
// formats store lanes and strobes, and aligns/extends load data for mem_wb_reg.
module mem_access_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_valid,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [2:0]            i_funct3,
  input  logic [DATA_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [DATA_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  output logic [3:0]            o_dmem_wstrb,
  input  logic                  i_dmem_ready,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  output logic [DATA_WIDTH-1:0] o_load_data,
  output logic                  o_stall,
  output logic                  o_fault
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                  state;
  state_t                  next_state;
  logic [15:0]             timeout_cnt;
  logic                    abort_flag;
  logic [DATA_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  logic [2:0]              acc_funct3;
  logic                    acc_we;
  logic [3:0]              acc_wstrb;

  logic                    start;
  logic                    bad;
  logic                    in_access;
  logic                    timeout_hit;
  logic [DATA_WIDTH-1:0]   fmt_wdata;
  logic [3:0]              fmt_wstrb;
  logic [7:0]              ld_byte;
  logic [15:0]             ld_half;
  logic [DATA_WIDTH-1:0]   fmt_rdata;

  assign start       = i_valid & (i_mem_read | i_mem_write);
  assign in_access   = (state == ACCESS);
  assign timeout_hit = (timeout_cnt == TIMEOUT_LAST);

  // A request with both read and write set is treated as a load.
  always_comb begin
    bad = 1'b0;
    if (i_mem_read) begin
      bad = (i_funct3 == 3'b011) | (i_funct3 == 3'b110) | (i_funct3 == 3'b111);
    end else begin
      bad = i_funct3[2] | (i_funct3[1:0] == 2'b11);
    end
    if ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00)) bad = 1'b1;
    if ((i_funct3[1:0] == 2'b01) && i_addr[0])               bad = 1'b1;
  end

  always_comb begin
    fmt_wdata = i_wdata;
    fmt_wstrb = 4'b1111;
    case (i_funct3[1:0])
      2'b00: begin
        fmt_wdata = {4{i_wdata[7:0]}};
        fmt_wstrb = 4'b0001 << i_addr[1:0];
      end
      2'b01: begin
        fmt_wdata = {2{i_wdata[15:0]}};
        fmt_wstrb = 4'b0011 << i_addr[1:0];
      end
      default: begin
        fmt_wdata = i_wdata;
        fmt_wstrb = 4'b1111;
      end
    endcase
  end

  always_comb begin
    ld_byte   = i_dmem_rdata[{acc_addr[1:0], 3'b000} +: 8];
    ld_half   = i_dmem_rdata[{acc_addr[1], 4'b0000} +: 16];
    fmt_rdata = i_dmem_rdata;
    case (acc_funct3)
      3'b000:  fmt_rdata = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  fmt_rdata = {{16{ld_half[15]}}, ld_half};
      3'b100:  fmt_rdata = {24'h0, ld_byte};
      3'b101:  fmt_rdata = {16'h0, ld_half};
      default: fmt_rdata = i_dmem_rdata;
    endcase
  end

  // Stall and fault are gated by reset so they drop the moment reset asserts.
  always_comb begin
    next_state = state;
    o_stall    = 1'b0;
    o_fault    = 1'b0;
    case (state)
      IDLE: begin
        if (start && !bad) begin
          next_state = ACCESS;
          o_stall    = i_rst_n;
        end
        if (start && bad) o_fault = i_rst_n;
      end
      ACCESS: begin
        o_stall = 1'b1;
        if (i_dmem_ready || timeout_hit) next_state = DONE;
      end
      DONE: begin
        o_fault    = abort_flag;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign o_dmem_req   = in_access;
  assign o_dmem_we    = in_access & acc_we;
  assign o_dmem_addr  = in_access ? {acc_addr[DATA_WIDTH-1:2], 2'b00} : '0;
  assign o_dmem_wdata = in_access ? acc_wdata : '0;
  assign o_dmem_wstrb = in_access ? acc_wstrb : 4'b0000;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      timeout_cnt <= '0;
      abort_flag  <= 1'b0;
      acc_addr    <= '0;
      acc_wdata   <= '0;
      acc_funct3  <= '0;
      acc_we      <= 1'b0;
      acc_wstrb   <= '0;
      o_load_data <= '0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: begin
          timeout_cnt <= '0;
          abort_flag  <= 1'b0;
          if (start && !bad) begin
            acc_addr   <= i_addr;
            acc_funct3 <= i_funct3;
            acc_we     <= ~i_mem_read;
            acc_wdata  <= fmt_wdata;
            acc_wstrb  <= i_mem_read ? 4'b0000 : fmt_wstrb;
          end
        end
        ACCESS: begin
          if (i_dmem_ready) begin
            timeout_cnt <= '0;
            if (!acc_we) o_load_data <= fmt_rdata;
          end else if (timeout_hit) begin
            timeout_cnt <= '0;
            abort_flag  <= 1'b1;
            o_load_data <= '0;
          end else begin
            timeout_cnt <= timeout_cnt + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage, built with a short
// timeout so the abort path is reachable in a few cycles.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_wstrb;
  logic        i_dmem_ready;
  logic [31:0] i_dmem_rdata;
  logic [31:0] o_load_data;
  logic        o_stall;
  logic        o_fault;

  int checks   = 0;
  int failures = 0;

  int          r_stall;
  int          r_req;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_we;
  logic        r_first_fault;
  logic        r_done_fault;
  logic        r_done_req;
  logic        r_timed_out;

  always #5 clk = ~clk;

  mem_access_stage #(
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_valid     (i_valid),
    .i_mem_read  (i_mem_read),
    .i_mem_write (i_mem_write),
    .i_funct3    (i_funct3),
    .i_addr      (i_addr),
    .i_wdata     (i_wdata),
    .o_dmem_req  (o_dmem_req),
    .o_dmem_we   (o_dmem_we),
    .o_dmem_addr (o_dmem_addr),
    .o_dmem_wdata(o_dmem_wdata),
    .o_dmem_wstrb(o_dmem_wstrb),
    .i_dmem_ready(i_dmem_ready),
    .i_dmem_rdata(i_dmem_rdata),
    .o_load_data (o_load_data),
    .o_stall     (o_stall),
    .o_fault     (o_fault)
  );

  // Presents one instruction, holds it until stall drops, then retires it.
  // ready_at is the ACCESS cycle (1-based) on which memory answers; 0 = never.
  task automatic run_access(input logic rd, input logic wr, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] wd,
                            input int ready_at, input logic [31:0] rdata);
    r_stall = 0; r_req = 0; r_addr = '0; r_wdata = '0; r_wstrb = '0; r_we = 1'b0;
    r_done_fault = 1'b0; r_done_req = 1'b0; r_timed_out = 1'b1;
    @(negedge clk);
    i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr; i_funct3 = f3;
    i_addr = addr; i_wdata = wd; i_dmem_ready = 1'b0; i_dmem_rdata = rdata;
    #1;
    r_first_fault = o_fault;
    if (o_dmem_req) r_req++;
    if (o_stall) begin
      r_stall++;
      for (int cyc = 1; cyc <= 40; cyc++) begin
        @(negedge clk);
        i_dmem_ready = (ready_at != 0) && (cyc == ready_at);
        #1;
        if (o_dmem_req) begin
          r_req++;
          if (r_req == 1) begin
            r_addr = o_dmem_addr; r_wdata = o_dmem_wdata;
            r_wstrb = o_dmem_wstrb; r_we = o_dmem_we;
          end
        end
        if (o_stall) begin
          r_stall++;
        end else begin
          r_done_fault = o_fault;
          r_done_req   = o_dmem_req;
          r_timed_out  = 1'b0;
          break;
        end
      end
    end else begin
      r_timed_out = 1'b0;
    end
    @(negedge clk);
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_dmem_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_funct3 = 3'b000; i_addr = '0; i_wdata = '0; i_dmem_ready = 1'b0; i_dmem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({o_dmem_req, o_dmem_we, o_dmem_wstrb, o_stall, o_fault} !== 8'h00) begin
      failures++;
      $display("[TB] FAIL reset_ctrl: got req=%b we=%b wstrb=%b stall=%b fault=%b, want all 0",
               o_dmem_req, o_dmem_we, o_dmem_wstrb, o_stall, o_fault);
    end
    checks++;
    if ({o_dmem_addr, o_dmem_wdata, o_load_data} !== 96'h0) begin
      failures++;
      $display("[TB] FAIL reset_data: got addr=%h wdata=%h load=%h, want 0",
               o_dmem_addr, o_dmem_wdata, o_load_data);
    end
    @(negedge clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_load_word();
    run_access(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 3, 32'hDEAD_BEEF);
    checks++;
    if (r_timed_out !== 1'b0) begin
      failures++; $display("[TB] FAIL lw_bound: stall never dropped");
    end
    checks++;
    if (r_stall != 4 || r_req != 3) begin
      failures++; $display("[TB] FAIL lw_latency: got stall=%0d req=%0d, want 4/3", r_stall, r_req);
    end
    checks++;
    if (r_addr !== 32'h10 || r_wstrb !== 4'b0000 || r_we !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lw_bus: got addr=%h wstrb=%b we=%b, want 10/0000/0", r_addr, r_wstrb, r_we);
    end
    checks++;
    if (r_done_req !== 1'b0 || r_done_fault !== 1'b0) begin
      failures++;
      $display("[TB] FAIL lw_done: got req=%b fault=%b, want 0/0", r_done_req, r_done_fault);
    end
    checks++;
    if (o_load_data !== 32'hDEAD_BEEF) begin
      failures++; $display("[TB] FAIL lw_data: got %h, want deadbeef", o_load_data);
    end
  endtask

  task automatic test_load_extend();
    logic [2:0]  f3  [3] = '{3'b000, 3'b100, 3'b001};
    logic [31:0] ad  [3] = '{32'h13, 32'h13, 32'h12};
    logic [31:0] rdw [3] = '{32'h8000_0000, 32'h8000_0000, 32'h8001_0000};
    logic [31:0] exp [3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8001};
    for (int i = 0; i < 3; i++) begin
      run_access(1'b1, 1'b0, f3[i], ad[i], 32'h0, 1, rdw[i]);
      checks++;
      if (r_stall != 2 || o_load_data !== exp[i]) begin
        failures++;
        $display("[TB] FAIL load_ext%0d: got stall=%0d data=%h, want 2/%h", i, r_stall, o_load_data, exp[i]);
      end
    end
  endtask

  task automatic test_store();
    logic [2:0]  f3  [3] = '{3'b000, 3'b001, 3'b010};
    logic [31:0] ad  [3] = '{32'h21, 32'h22, 32'h24};
    logic [31:0] ead [3] = '{32'h20, 32'h20, 32'h24};
    logic [31:0] ewd [3] = '{32'hABAB_ABAB, 32'h56AB_56AB, 32'h1234_56AB};
    logic [3:0]  est [3] = '{4'b0010, 4'b1100, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      run_access(1'b0, 1'b1, f3[i], ad[i], 32'h1234_56AB, 2, 32'hFFFF_FFFF);
      checks++;
      if (r_we !== 1'b1 || r_addr !== ead[i] || r_wdata !== ewd[i] || r_wstrb !== est[i]) begin
        failures++;
        $display("[TB] FAIL store%0d: got we=%b addr=%h wdata=%h wstrb=%b, want 1/%h/%h/%b",
                 i, r_we, r_addr, r_wdata, r_wstrb, ead[i], ewd[i], est[i]);
      end
      checks++;
      if (o_load_data !== 32'hFFFF_8001) begin
        failures++; $display("[TB] FAIL store%0d_keep: load=%h, want ffff8001", i, o_load_data);
      end
    end
  endtask

  task automatic test_misaligned();
    logic        rd [3] = '{1'b1, 1'b0, 1'b1};
    logic [2:0]  f3 [3] = '{3'b010, 3'b001, 3'b011};
    logic [31:0] ad [3] = '{32'h6, 32'h5, 32'h0};
    for (int i = 0; i < 3; i++) begin
      run_access(rd[i], ~rd[i], f3[i], ad[i], 32'h5555_5555, 1, 32'h0);
      checks++;
      if (r_first_fault !== 1'b1 || r_req != 0 || r_stall != 0) begin
        failures++;
        $display("[TB] FAIL bad%0d: got fault=%b req=%0d stall=%0d, want 1/0/0",
                 i, r_first_fault, r_req, r_stall);
      end
      checks++;
      if (o_fault !== 1'b0 || o_load_data !== 32'hFFFF_8001) begin
        failures++;
        $display("[TB] FAIL bad%0d_after: got fault=%b load=%h, want 0/ffff8001", i, o_fault, o_load_data);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    @(negedge clk);
    i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0; i_funct3 = 3'b010;
    i_addr = 32'h40; i_dmem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (o_dmem_req !== 1'b1) begin
      failures++; $display("[TB] FAIL rst_pre: req=%b, want 1", o_dmem_req);
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_dmem_req !== 1'b0 || o_stall !== 1'b0 || o_fault !== 1'b0 || o_load_data !== 32'h0) begin
      failures++;
      $display("[TB] FAIL rst_mid: got req=%b stall=%b fault=%b load=%h, want 0/0/0/0",
               o_dmem_req, o_stall, o_fault, o_load_data);
    end
    @(negedge clk);
    i_valid = 1'b0; i_mem_read = 1'b0;
    @(negedge clk);
    i_rst_n = 1'b1;
    run_access(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 1, 32'hCAFE_F00D);
    checks++;
    if (r_stall != 2 || r_addr !== 32'h44 || o_load_data !== 32'hCAFE_F00D) begin
      failures++;
      $display("[TB] FAIL rst_recover: got stall=%0d addr=%h load=%h, want 2/44/cafef00d",
               r_stall, r_addr, o_load_data);
    end
  endtask

  task automatic test_timeout();
    run_access(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 0, 32'h1111_1111);
    checks++;
    if (r_timed_out !== 1'b0 || r_req != 4 || r_stall != 5) begin
      failures++;
      $display("[TB] FAIL timeout_len: got bound=%b req=%0d stall=%0d, want 0/4/5", r_timed_out, r_req, r_stall);
    end
    checks++;
    if (r_done_fault !== 1'b1 || o_load_data !== 32'h0) begin
      failures++;
      $display("[TB] FAIL timeout_fault: got fault=%b load=%h, want 1/0", r_done_fault, o_load_data);
    end
  endtask

  initial begin
    test_reset();
    test_load_word();
    test_load_extend();
    test_store();
    test_misaligned();
    test_reset_mid_access();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
